// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the multiply/divide unit: operation encoding, FSM
// state encoding, default latencies and the busy-counter width.
// -----------------------------------------------------------------------------
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MADD  = 3'd6,
        OP_MSUB  = 3'd7
    } mdu_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_t;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_MUL_CYCLES = 5;
    localparam int DEF_DIV_CYCLES = 10;

    // Latencies are limited to 1..31, so five bits hold the busy count.
    localparam int CNT_W = 5;

endpackage

// File: rtl/mdu_arith.sv
// -----------------------------------------------------------------------------
// mdu_arith
// Purely combinational arithmetic core of the MDU. Produces the signed and
// unsigned double-width products and the signed/unsigned quotient and
// remainder of the captured operands.
//
// Ports
//   a, b      in   WIDTH     captured operands (dividend/multiplicand, divisor/multiplier)
//   prod_s    out  2*WIDTH   signed product
//   prod_u    out  2*WIDTH   unsigned product
//   quot_s    out  WIDTH     signed quotient, truncated toward zero
//   rem_s     out  WIDTH     signed remainder, sign of the dividend
//   quot_u    out  WIDTH     unsigned quotient
//   rem_u     out  WIDTH     unsigned remainder
//   div_zero  out  1         divisor is zero; quotient/remainder are don't-care
// -----------------------------------------------------------------------------
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
)
(
    input  logic [WIDTH-1:0]          a,
    input  logic [WIDTH-1:0]          b,
    output logic signed [2*WIDTH-1:0] prod_s,
    output logic [2*WIDTH-1:0]        prod_u,
    output logic signed [WIDTH-1:0]   quot_s,
    output logic signed [WIDTH-1:0]   rem_s,
    output logic [WIDTH-1:0]          quot_u,
    output logic [WIDTH-1:0]          rem_u,
    output logic                      div_zero
);

    localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] S_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // MIN / -1 overflows the quotient. Dividing by +1 instead yields exactly
    // the wrapped result (quotient MIN, remainder 0). A zero divisor is also
    // replaced by 1 so the divider never sees an undefined case.
    function automatic logic signed [WIDTH-1:0] safe_divisor_s(
        input logic signed [WIDTH-1:0] n,
        input logic signed [WIDTH-1:0] d
    );
        if (d == '0 || (n == S_MIN && d == '1)) begin
            return S_ONE;
        end
        return d;
    endfunction

    function automatic logic [WIDTH-1:0] safe_divisor_u(input logic [WIDTH-1:0] d);
        return (d == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : d;
    endfunction

    logic signed [WIDTH-1:0]   a_s;
    logic signed [WIDTH-1:0]   b_s;
    logic signed [WIDTH-1:0]   b_div_s;
    logic [WIDTH-1:0]          b_div_u;
    logic signed [2*WIDTH-1:0] a_ext;
    logic signed [2*WIDTH-1:0] b_ext;

    always_comb begin
        a_s     = $signed(a);
        b_s     = $signed(b);
        a_ext   = {{WIDTH{a[WIDTH-1]}}, a};
        b_ext   = {{WIDTH{b[WIDTH-1]}}, b};
        prod_s  = a_ext * b_ext;
        prod_u  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

        div_zero = (b == '0);
        b_div_s  = safe_divisor_s(a_s, b_s);
        b_div_u  = safe_divisor_u(b);
        quot_s   = a_s / b_div_s;
        rem_s    = a_s % b_div_s;
        quot_u   = a / b_div_u;
        rem_u    = a % b_div_u;
    end

endmodule

// File: rtl/mdu.sv
// -----------------------------------------------------------------------------
// mdu
// Multi-cycle multiply/divide unit with HI/LO result registers.
// MULT/MULTU run MUL_CYCLES busy cycles, DIV/DIVU run DIV_CYCLES busy cycles;
// results land in HI/LO on the edge that drops busy. MTHI/MTLO write HI/LO
// directly on acceptance. Operands are captured at acceptance.
//
// Optional feature: define MDU_MADD_EN to enable MADD/MSUB (multiply-
// accumulate into {hi,lo}). Without it, ops 6/7 are no-ops.
//
// Ports
//   clk    in   1      clock, rising edge
//   reset  in   1      synchronous active-high reset
//   start  in   1      issue strobe, accepted only when busy=0
//   op     in   3      operation code (mdu_op_t)
//   a      in   WIDTH  first operand
//   b      in   WIDTH  second operand
//   busy   out  1      multi-cycle operation in flight
//   hi     out  WIDTH  HI register
//   lo     out  WIDTH  LO register
// -----------------------------------------------------------------------------
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_t       state;
    mdu_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             capture;
    logic             accept;
    logic             done;
    mdu_op_t          op_in;
    mdu_op_t          op_p0;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;

    logic signed [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0]        prod_u;
    logic signed [WIDTH-1:0]   quot_s;
    logic signed [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]          quot_u;
    logic [WIDTH-1:0]          rem_u;
    logic                      div_zero;

    assign op_in  = mdu_op_t'(op);
    assign accept = start && (state == ST_IDLE);

    mdu_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .a        (a_p0),
        .b        (b_p0),
        .prod_s   (prod_s),
        .prod_u   (prod_u),
        .quot_s   (quot_s),
        .rem_s    (rem_s),
        .quot_u   (quot_u),
        .rem_u    (rem_u),
        .div_zero (div_zero)
    );

    // ---- FSM state register, busy counter and operand capture ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_p0 <= OP_MULT;
            a_p0  <= '0;
            b_p0  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (capture) begin
                op_p0 <= op_in;
                a_p0  <= a;
                b_p0  <= b;
            end
        end
    end

    // ---- FSM next-state logic ----
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    case (op_in)
                        OP_MULT, OP_MULTU: begin
                            state_nxt = ST_BUSY;
                            cnt_nxt   = CNT_W'(MUL_CYCLES);
                            capture   = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_nxt = ST_BUSY;
                            cnt_nxt   = CNT_W'(DIV_CYCLES);
                            capture   = 1'b1;
                        end
`ifdef MDU_MADD_EN
                        OP_MADD, OP_MSUB: begin
                            state_nxt = ST_BUSY;
                            cnt_nxt   = CNT_W'(MUL_CYCLES);
                            capture   = 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                // cnt holds the busy cycles remaining including the current one
                if (cnt == CNT_W'(1)) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // ---- FSM outputs and HI/LO next values ----
    always_comb begin
        busy   = (state == ST_BUSY);
        done   = busy && (cnt == CNT_W'(1));
        hi_nxt = hi;
        lo_nxt = lo;

        if (accept) begin
            case (op_in)
                OP_MTHI: hi_nxt = a;
                OP_MTLO: lo_nxt = a;
                default: ;
            endcase
        end

        if (done) begin
            case (op_p0)
                OP_MULT:  {hi_nxt, lo_nxt} = prod_s;
                OP_MULTU: {hi_nxt, lo_nxt} = prod_u;
                OP_DIV: begin
                    // divide by zero leaves HI/LO untouched
                    if (!div_zero) begin
                        lo_nxt = quot_s;
                        hi_nxt = rem_s;
                    end
                end
                OP_DIVU: begin
                    if (!div_zero) begin
                        lo_nxt = quot_u;
                        hi_nxt = rem_u;
                    end
                end
`ifdef MDU_MADD_EN
                // accumulator is the {hi,lo} value at completion, wrapping mod 2^(2*WIDTH)
                OP_MADD:  {hi_nxt, lo_nxt} = {hi, lo} + prod_s;
                OP_MSUB:  {hi_nxt, lo_nxt} = {hi, lo} - prod_s;
`endif
                default: ;
            endcase
        end
    end

    // ---- HI/LO result registers ----
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else begin
            hi <= hi_nxt;
            lo <= lo_nxt;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// -----------------------------------------------------------------------------
// tb_mdu
// Self-checking bench for mdu with a scoreboard: every issued operation pushes
// its expected busy length and HI/LO into a queue; the entry is popped and
// compared when the DUT drops busy (or right after acceptance for MTHI/MTLO).
// Honours MDU_MADD_EN the same way the RTL does.
// -----------------------------------------------------------------------------
module tb_mdu;
    import mdu_pkg::*;

    localparam int W    = 32;
    localparam int MULC = 5;
    localparam int DIVC = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    mdu #(
        .WIDTH      (W),
        .MUL_CYCLES (MULC),
        .DIV_CYCLES (DIVC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] hold_hi;
        logic [W-1:0] hold_lo;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic [7:0]   cycles;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    // reference HI/LO state
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Reference model using 64-bit host arithmetic.
    task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [7:0] cyc);
        longint      sx;
        longint      sy;
        longint      p;
        logic [63:0] pu;
        logic [63:0] acc;
        sx  = $signed(x);
        sy  = $signed(y);
        cyc = 8'd0;
        acc = '0;
        case (o)
            3'd0: begin p = sx * sy; {m_hi, m_lo} = p; cyc = 8'(MULC); end
            3'd1: begin pu = {32'b0, x} * {32'b0, y}; {m_hi, m_lo} = pu; cyc = 8'(MULC); end
            3'd2: begin
                cyc = 8'(DIVC);
                if (y != 0) begin
                    p = sx / sy;
                    m_lo = p[W-1:0];
                    p = sx % sy;
                    m_hi = p[W-1:0];
                end
            end
            3'd3: begin
                cyc = 8'(DIVC);
                if (y != 0) begin
                    m_lo = x / y;
                    m_hi = x % y;
                end
            end
            3'd4: m_hi = x;
            3'd5: m_lo = x;
            default: begin
`ifdef MDU_MADD_EN
                cyc = 8'(MULC);
                p   = sx * sy;
                acc = {m_hi, m_lo};
                acc = (o == 3'd6) ? acc + p : acc - p;
                {m_hi, m_lo} = acc;
`endif
            end
        endcase
    endtask

    // Issue one op at the current negedge, then collect its result.
    // disturb_at>0: at that busy cycle, try to issue MTLO 0xAAAA (must be ignored).
    task automatic run(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input int disturb_at);
        exp_t  e;
        exp_t  g;
        string t;
        int    seen;
        e.hold_hi = m_hi;
        e.hold_lo = m_lo;
        model(o, x, y, e.cycles);
        e.hi = m_hi;
        e.lo = m_lo;
        exp_q.push_back(e);
        tag_q.push_back(tag);

        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = ~x; b = ~y;   // operands change after acceptance
        seen = 0;
        while (busy && seen < 64) begin
            seen++;
            if (seen == 1) begin
                check({tag, ".hold_hi"}, 64'(hi), 64'(exp_q[0].hold_hi));
                check({tag, ".hold_lo"}, 64'(lo), 64'(exp_q[0].hold_lo));
            end
            if (seen == disturb_at) begin
                start = 1'b1; op = 3'd5; a = 32'h0000AAAA;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        g = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, ".cycles"}, 64'(seen), 64'(g.cycles));
        check({t, ".hi"}, 64'(hi), 64'(g.hi));
        check({t, ".lo"}, 64'(lo), 64'(g.lo));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.hi", 64'(hi), 64'd0);
        check("reset.lo", 64'(lo), 64'd0);

        run("mult_neg1x2",  3'd0, 32'hFFFFFFFF, 32'h00000002, 0);
        check("mult_const.hi", 64'(hi), 64'hFFFFFFFF);
        check("mult_const.lo", 64'(lo), 64'hFFFFFFFE);
        run("multu_max2",   3'd1, 32'hFFFFFFFF, 32'h00000002, 0);
        check("multu_const.hi", 64'(hi), 64'h00000001);
        run("div_m7_2",     3'd2, 32'hFFFFFFF9, 32'h00000002, 0);
        check("div_const.lo", 64'(lo), 64'hFFFFFFFD);
        check("div_const.hi", 64'(hi), 64'hFFFFFFFF);
        run("div_min_m1",   3'd2, 32'h80000000, 32'hFFFFFFFF, 0);
        check("div_ovf_const.lo", 64'(lo), 64'h80000000);
        run("mthi",         3'd4, 32'h00001234, 32'h0, 0);
        run("mtlo",         3'd5, 32'h00005678, 32'h0, 0);
        run("divu_by_zero", 3'd3, 32'h0000FFFF, 32'h0, 0);
        check("divz_const.hi", 64'(hi), 64'h1234);
        check("divz_const.lo", 64'(lo), 64'h5678);
        run("div_busy_mtlo", 3'd2, 32'd100, 32'd7, 3);
        check("busy_ignore.lo", 64'(lo), 64'd14);

        run("mthi0",  3'd4, 32'd0, 32'd0, 0);
        run("mtlo10", 3'd5, 32'd10, 32'd0, 0);
        run("madd",   3'd6, 32'd3, 32'hFFFFFFFE, 0);
`ifdef MDU_MADD_EN
        check("madd_const.lo", 64'(lo), 64'd4);
`else
        check("madd_const.lo", 64'(lo), 64'd10);
`endif
        run("msub",   3'd7, 32'd5, 32'd7, 0);
        run("div_rem_neg", 3'd2, 32'd17, 32'hFFFFFFFB, 0);

        for (int i = 0; i < 16; i++) begin
            logic [2:0]   ro;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i % 5 == 0) rb = -rb;
            run($sformatf("rand%0d", i), ro, ra, rb, 0);
        end

        // reset in the middle of a multiply
        run("pre_reset", 3'd1, 32'h12345678, 32'h00000100, 0);
        start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);            // busy cycle 2
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.hi", 64'(hi), 64'd0);
        check("abort.lo", 64'(lo), 64'd0);
        repeat (8) @(negedge clk);
        check("abort_late.hi", 64'(hi), 64'd0);
        check("abort_late.lo", 64'(lo), 64'd0);
        check("abort_late.busy", 64'(busy), 64'd0);

        run("post_reset", 3'd0, 32'hFFFFFFFD, 32'd7, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand, HI and LO width; legal range 8..64.
REQ-002 SHALL have parameter MUL_CYCLES, default 5: busy cycles for multiply operations; legal range 1..31.
REQ-003 SHALL have parameter DIV_CYCLES, default 10: busy cycles for divide operations; legal range 1..31.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  issue strobe; sampled every cycle.
REQ-007 SHALL have port op  input  3  operation code, per the shared package encoding.
REQ-008 SHALL have port a  input  WIDTH  first operand (dividend / multiplicand / move source).
REQ-009 SHALL have port b  input  WIDTH  second operand (divisor / multiplier).
REQ-010 SHALL have port busy  output  1  high while a multiply or divide is in flight.
REQ-011 SHALL have port hi  output  WIDTH  HI register.
REQ-012 SHALL have port lo  output  WIDTH  LO register.

Function
REQ-013 SHALL decode op as: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB.
REQ-014 SHALL accept an operation only when start=1 and busy=0.
REQ-015 SHALL ignore start while busy=1; no state change, no queuing.
REQ-016 SHALL capture a and b at acceptance, so operand changes during busy have no effect.
REQ-017 SHALL, for an accepted MULT/MULTU/DIV/DIVU, assert busy from the next cycle for exactly MUL_CYCLES or DIV_CYCLES cycles.
REQ-018 SHALL update hi and lo on the same edge that deasserts busy; hi and lo stay unchanged while busy=1.
REQ-019 SHALL write MULT/MULTU results as {hi,lo} = the full 2*WIDTH-bit signed/unsigned product.
REQ-020 SHALL write DIV/DIVU results as lo=quotient and hi=remainder.
REQ-021 SHALL truncate signed quotients toward zero; the remainder SHALL take the sign of the dividend.
REQ-022 SHALL, for signed MIN/-1, set lo=MIN and hi=0 with no error flag.
REQ-023 SHALL, on divide by zero, still run DIV_CYCLES cycles and leave hi and lo unchanged.
REQ-024 SHALL, for MTHI/MTLO, write a into hi/lo on the acceptance edge, with busy staying 0.
REQ-025 SHALL treat back-to-back issue as legal: start may be accepted in the cycle after busy falls.

Reset
REQ-026 SHALL, when reset=1 at a clock edge, set hi=0, lo=0, busy=0, and clear the cycle counter and captured operands.
REQ-027 SHALL, on reset during busy, abort the operation with no HI/LO write.
REQ-028 SHALL give reset priority over start in the same cycle.

Configuration
REQ-029 SHALL, with MDU_MADD_EN defined, make MADD/MSUB run MUL_CYCLES cycles and then write {hi,lo} = {hi,lo} +/- signed(a*b).
REQ-030 SHALL use for MADD/MSUB the {hi,lo} value at completion, modulo 2^(2*WIDTH).
REQ-031 SHALL, without MDU_MADD_EN, treat op 6/7 as no-ops: busy stays 0 and hi/lo are unchanged.

Structure
REQ-032 SHALL place the op enum (mdu_op_t) and the default latency constants in package mdu_pkg.
REQ-033 SHALL compute results combinationally from captured operands at completion in a single sub-module mdu_arith (pure combinational: product, quotient, remainder).
REQ-034 SHALL hold in mdu itself the state machine IDLE -> BUSY(count) -> IDLE, plus the HI/LO registers.

Verification
REQ-035 SHALL test MULT a=0xFFFFFFFF, b=0x00000002 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-036 SHALL test DIV a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 SHALL test DIVU by b=0 after MTHI 0x1234 and MTLO 0x5678 -> busy 10 cycles, then hi=0x1234, lo=0x5678.
REQ-038 SHALL test start DIV, then MTLO 0xAAAA with start at busy cycle 3 -> the MTLO is ignored and lo = quotient at completion.
REQ-039 SHALL test reset asserted at busy cycle 2 of a MULT -> next cycle busy=0, hi=0, lo=0, and no later write occurs.
REQ-040 SHALL test, with MDU_MADD_EN, MTHI 0, MTLO 10, MADD a=3, b=-2 -> hi=0, lo=4; without the macro -> busy stays 0 and lo=10.
